karatsuba_seq: RTL and testbench

Parametrised, multi-cycle unsigned Karatsuba multiplier with valid/ready handshakes on input and output. It splits each W-bit operand into high and low halves and computes the three Karatsuba partial products one per cycle on a single shared (W/2+1)-bit multiplier. It then combines them into the exact 2W-bit product. It is the sequential, width-generic successor to the fixed 8-bit combinational multiplier and sits between operand producers and result consumers in the arithmetic datapath.

---
 rtl/karatsuba_seq.sv | 115 +++++++++++
 tb/tb_karatsuba_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/karatsuba_seq.sv
// Sequential unsigned Karatsuba multiplier: three partial products on one shared
// (W/2+1)-bit multiplier, recombined into the exact 2W-bit product.
module karatsuba_seq #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   X,
  input  logic [W-1:0]   Y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] Z
);
  localparam int H = W / 2;

  typedef enum logic [2:0] {IDLE, P_HI, P_LO, P_MID, SUM, DONE} state_t;

  state_t               state_reg, state_next;
  logic [W-1:0]         x_reg, x_next, y_reg, y_next;
  logic [2*H-1:0]       a_reg, a_next, b_reg, b_next;
  logic [2*H+1:0]       c_reg, c_next;
  logic [2*W-1:0]       z_reg, z_next;

  logic [H-1:0]         xh, xl, yh, yl;
  logic [H:0]           mul_a, mul_b;
  logic [2*H+1:0]       prod;
  logic [2*H+1:0]       mid;
  logic [2*W-1:0]       z_sum;
  logic                 accept;

  genvar gi;
  generate
    for (gi = 0; gi < H; gi++) begin : g_split
      assign xl[gi] = x_reg[gi];
      assign xh[gi] = x_reg[gi+H];
      assign yl[gi] = y_reg[gi];
      assign yh[gi] = y_reg[gi+H];
    end
  endgenerate

  assign in_ready  = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_reg == DONE);
  assign Z         = z_reg;

  // Single shared multiplier; operand selection depends only on the state.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_reg)
      P_HI:  begin mul_a = {1'b0, xh}; mul_b = {1'b0, yh}; end
      P_LO:  begin mul_a = {1'b0, xl}; mul_b = {1'b0, yl}; end
      P_MID: begin
        mul_a = {1'b0, xh} + {1'b0, xl};
        mul_b = {1'b0, yh} + {1'b0, yl};
      end
      default: ;
    endcase
  end

  assign prod = {{(H+1){1'b0}}, mul_a} * {{(H+1){1'b0}}, mul_b};

  // Middle term is non-negative, evaluated at 2h+2 bits so nothing wraps.
  assign mid   = c_reg - {2'b00, a_reg} - {2'b00, b_reg};
  assign z_sum = {a_reg, {W{1'b0}}}
               + ({{(2*W-2*H-2){1'b0}}, mid} << H)
               + {{(2*W-2*H){1'b0}}, b_reg};

  always_comb begin
    state_next = state_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    c_next     = c_reg;
    z_next     = z_reg;
    if (accept) begin
      x_next = X;
      y_next = Y;
    end
    case (state_reg)
      IDLE:  if (in_valid) state_next = P_HI;
      P_HI:  begin a_next = prod[2*H-1:0]; state_next = P_LO;  end
      P_LO:  begin b_next = prod[2*H-1:0]; state_next = P_MID; end
      P_MID: begin c_next = prod;          state_next = SUM;   end
      SUM:   begin z_next = z_sum;         state_next = DONE;  end
      DONE: begin
        if (out_ready) state_next = in_valid ? P_HI : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      x_reg     <= '0;
      y_reg     <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      c_reg     <= '0;
      z_reg     <= '0;
    end else begin
      state_reg <= state_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      c_reg     <= c_next;
      z_reg     <= z_next;
    end
  end
endmodule

// File: tb/tb_karatsuba_seq.sv
// Directed bench for karatsuba_seq: W=16 and W=8 instances sharing one clock.
module tb_karatsuba_seq;
  logic        clk, rst_n;
  logic        iv16, ir16, ov16, or16;
  logic [15:0] x16, y16;
  logic [31:0] z16;
  logic        iv8, ir8, ov8, or8;
  logic [7:0]  x8, y8;
  logic [15:0] z8;
  int total = 0;
  int bad   = 0;

  karatsuba_seq #(.W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .X(x16), .Y(y16),
    .out_valid(ov16), .out_ready(or16), .Z(z16)
  );
  karatsuba_seq #(.W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .X(x8), .Y(y8),
    .out_valid(ov8), .out_ready(or8), .Z(z8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic mul16(input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] exp, input string tag);
    int lat;
    @(negedge clk);
    check({tag, "_rdy"}, {63'd0, ir16}, 64'd1);
    iv16 = 1'b1; x16 = a; y16 = b;
    @(posedge clk);
    @(negedge clk);
    iv16 = 1'b0; x16 = ~a; y16 = ~b;
    lat = 0;
    while (!ov16 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'd4);
    check({tag, "_z"}, {32'd0, z16}, {32'd0, exp});
    $display("txn %s W=16 X=%h Y=%h Z=%h", tag, a, b, z16);
  endtask

  task automatic mul8(input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] exp, input string tag, input bit quiet);
    int lat;
    @(negedge clk);
    iv8 = 1'b1; x8 = a; y8 = b;
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0; x8 = ~a;
    lat = 0;
    while (!ov8 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'd4);
    check({tag, "_z"}, {48'd0, z8}, {48'd0, exp});
    if (!quiet) $display("txn %s W=8 X=%h Y=%h Z=%h", tag, a, b, z8);
  endtask

  logic [15:0] sx [8];
  logic [15:0] sy [8];
  logic [31:0] sz [8];

  initial begin
    int lat;
    bit seen;
    logic [7:0] ra, rb;
    rst_n = 1'b1;
    iv16 = 1'b0; or16 = 1'b1; x16 = '0; y16 = '0;
    iv8  = 1'b0; or8  = 1'b1; x8  = '0; y8  = '0;
    #3 rst_n = 1'b0;
    #4;
    check("rst_ready", {63'd0, ir16}, 64'd1);
    check("rst_valid", {63'd0, ov16}, 64'd0);
    check("rst_z", {32'd0, z16}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed W=16 products
    mul16(16'h1234, 16'h5678, 32'h06260060, "d1234");
    mul16(16'hFFFF, 16'hFFFF, 32'hFFFE0001, "dffff");
    mul16(16'h0000, 16'hABCD, 32'h00000000, "dzero");
    mul16(16'h8000, 16'h8000, 32'h40000000, "d8000");
    mul16(16'h00FF, 16'h0101, 32'h0000FFFF, "d00ff");

    // W=8 directed and random
    mul8(8'hFF, 8'hFF, 16'hFE01, "e_ff", 1'b0);
    mul8(8'h5A, 8'h3C, 16'h1518, "e_5a", 1'b0);
    for (int i = 0; i < 300; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      mul8(ra, rb, 16'(ra) * 16'(rb), "rand8", 1'b1);
      $display("txn rand8 W=8 X=%h Y=%h Z=%h", ra, rb, z8);
    end

    // Backpressure: result held 7 cycles, in_valid pulses ignored
    @(negedge clk);
    or16 = 1'b0; iv16 = 1'b1; x16 = 16'h0003; y16 = 16'h0005;
    @(posedge clk);
    @(negedge clk);
    iv16 = 1'b0;
    lat = 0;
    while (!ov16 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("bp_lat", 64'(lat), 64'd4);
    for (int k = 0; k < 7; k++) begin
      iv16 = (k % 2 == 0); x16 = 16'hFFFF; y16 = 16'hFFFF;
      @(negedge clk);
      check("bp_valid", {63'd0, ov16}, 64'd1);
      check("bp_z", {32'd0, z16}, 64'h0000000F);
      check("bp_ready", {63'd0, ir16}, 64'd0);
    end
    $display("txn bp W=16 X=0003 Y=0005 Z=%h", z16);
    iv16 = 1'b1; x16 = 16'h0100; y16 = 16'h0100; or16 = 1'b1;
    #1;
    check("bp_ready_comb", {63'd0, ir16}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    iv16 = 1'b0;
    check("bp_drop", {63'd0, ov16}, 64'd0);
    lat = 0;
    while (!ov16 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("bp2_lat", 64'(lat), 64'd4);
    check("bp2_z", {32'd0, z16}, 64'h00010000);
    $display("txn bp2 W=16 X=0100 Y=0100 Z=%h", z16);

    // Back-to-back stream, one result every 5 cycles
    sx[0] = 16'h0002; sy[0] = 16'h0003; sz[0] = 32'h00000006;
    sx[1] = 16'h00FF; sy[1] = 16'h0101; sz[1] = 32'h0000FFFF;
    sx[2] = 16'h0100; sy[2] = 16'h00FF; sz[2] = 32'h0000FF00;
    sx[3] = 16'hFFFF; sy[3] = 16'h0001; sz[3] = 32'h0000FFFF;
    sx[4] = 16'h1000; sy[4] = 16'h0010; sz[4] = 32'h00010000;
    sx[5] = 16'h00FF; sy[5] = 16'h00FF; sz[5] = 32'h0000FE01;
    sx[6] = 16'hFF00; sy[6] = 16'hFF00; sz[6] = 32'hFE010000;
    sx[7] = 16'h0001; sy[7] = 16'h0001; sz[7] = 32'h00000001;
    @(negedge clk);
    @(negedge clk);
    iv16 = 1'b1; x16 = sx[0]; y16 = sy[0];
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (3) @(posedge clk);
      #1;
      check("stream_early", {63'd0, ov16}, 64'd0);
      @(posedge clk);
      #1;
      check("stream_valid", {63'd0, ov16}, 64'd1);
      check("stream_z", {32'd0, z16}, {32'd0, sz[i]});
      $display("txn stream%0d W=16 X=%h Y=%h Z=%h", i, sx[i], sy[i], z16);
      if (i < 7) begin
        x16 = sx[i+1]; y16 = sy[i+1];
      end else begin
        iv16 = 1'b0;
      end
      @(posedge clk);
    end
    #1;
    check("stream_end", {63'd0, ov16}, 64'd0);

    // Asynchronous reset while in P_LO
    @(negedge clk);
    iv16 = 1'b1; x16 = 16'h1234; y16 = 16'h5678;
    @(posedge clk);
    @(negedge clk);
    iv16 = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", {63'd0, ov16}, 64'd0);
    check("rst_mid_z", {32'd0, z16}, 64'd0);
    check("rst_mid_ready", {63'd0, ir16}, 64'd1);
    #3 rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (ov16) seen = 1'b1;
    end
    check("rst_no_stale", {63'd0, seen}, 64'd0);
    mul16(16'h0010, 16'h0010, 32'h00000100, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
